module_debounce_gray: RTL and testbench

- Input conditioning stage directly upstream of the Gray-code reader/decoder.
- Synchronises the raw Gray-code switch inputs (DIP switches, unconstrained timing) into clk_i.
- Debounces each bit independently and presents a clean, stable code plus a one-cycle change strobe.
- Its output feeds the decoder's Gray input in place of the raw pins; that decoder can then run at display-rate refresh without bounce artefacts.

---
 rtl/module_debounce_gray_pkg.sv | 20 ++
 rtl/module_debounce_gray_bit.sv | 63 ++++++
 rtl/module_debounce_gray.sv | 80 ++++++++
 tb/tb_module_debounce_gray.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/module_debounce_gray_pkg.sv
// Shared constants and helpers for the Gray-code switch conditioning path.
// Default debounce window: DEBOUNCE_MS at CLK_HZ.
package module_debounce_gray_pkg;

   localparam int CLK_HZ                = 27000000;
   localparam int DEBOUNCE_MS           = 10;
   localparam int STABLE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int SYNC_STAGES_DEFAULT   = 2;
   localparam int WIDTH_DEFAULT         = 4;

   // Bits needed to hold 0..max_count; also used by the display refresh counters.
   function automatic int cnt_width(input int max_count);
      if (max_count < 1) begin
         return 1;
      end else begin
         return $clog2(max_count + 1);
      end
   endfunction

endpackage

// File: rtl/module_debounce_gray_bit.sv
// One switch bit: SYNC_STAGES-deep synchroniser followed by a stability counter.
// update_o is the combinational enable that loads clean_o on the next edge.
module module_debounce_bit
   import module_debounce_gray_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic clean_o,
   output logic update_o
);

   localparam int            CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] TERMINAL = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_bit;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_next;
   logic                   clean_next;

   // Synchroniser chain; the oldest stage is the only one the counter looks at.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign sync_bit = sync_chain[SYNC_STAGES-1];

   // Count consecutive disagreement cycles; any agreement restarts from zero.
   always_comb begin
      cnt_next   = cnt;
      clean_next = clean_o;
      update_o   = 1'b0;
      if (sync_bit == clean_o) begin
         cnt_next = '0;
      end else if (cnt == TERMINAL) begin
         cnt_next   = '0;
         clean_next = sync_bit;
         update_o   = ~rst_i;
      end else begin
         cnt_next = cnt + CW'(1);
      end
   end

   // Counter and clean level registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt     <= '0;
         clean_o <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         clean_o <= clean_next;
      end
   end

endmodule

// File: rtl/module_debounce_gray.sv
// Debounced, synchronised Gray-code input with a one-cycle change strobe.
// Optional macro GRAY_CHECK_EN enables the sticky multi-bit-step flag gray_err_o.
module module_debounce_gray
   import module_debounce_gray_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEFAULT,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] gray_raw_i,
   output logic [WIDTH-1:0] gray_clean_o,
   output logic             change_o,
   output logic             gray_err_o
);

   logic [WIDTH-1:0] clean_bits;
   logic [WIDTH-1:0] update_bits;

   genvar b;
   generate
      for (b = 0; b < WIDTH; b++) begin : g_bit
         module_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
         ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (gray_raw_i[b]),
            .clean_o  (clean_bits[b]),
            .update_o (update_bits[b])
         );
      end
   endgenerate

   assign gray_clean_o = clean_bits;

   // Strobe lands in the same cycle the new clean code becomes visible.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         change_o <= 1'b0;
      end else begin
         change_o <= |update_bits;
      end
   end

`ifdef GRAY_CHECK_EN
   // An updating bit always flips, so the update mask equals old ^ new.
   function automatic int unsigned count_ones(input logic [WIDTH-1:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            n = n + 32'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   logic multi_step;
   assign multi_step = (count_ones(update_bits) > 32'd1);

   // Sticky until reset so a single bad step is never lost.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gray_err_o <= 1'b0;
      end else if (multi_step) begin
         gray_err_o <= 1'b1;
      end else begin
         gray_err_o <= gray_err_o;
      end
   end
`else
   assign gray_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_module_debounce_gray.sv
// Scoreboard bench: a window-based reference model predicts every change pulse,
// a negedge monitor checks clean code, pulses and error flag cycle by cycle.
module tb_module_debounce_gray;

   localparam int WIDTH  = 4;
   localparam int STABLE = 8;
   localparam int SYNC   = 2;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [WIDTH-1:0] gray_raw_i = '0;
   logic [WIDTH-1:0] gray_clean_o;
   logic             change_o;
   logic             gray_err_o;

   always #5 clk_i = ~clk_i;

   module_debounce_gray #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .gray_raw_i   (gray_raw_i),
      .gray_clean_o (gray_clean_o),
      .change_o     (change_o),
      .gray_err_o   (gray_err_o)
   );

   typedef struct {
      logic [WIDTH-1:0] clean;
      logic             err;
      int               edge_no;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] m_clean = '0;
   logic             m_err   = 1'b0;
   logic [WIDTH-1:0] m_line[$];
   logic [WIDTH-1:0] m_hist[$];
   int               edge_cnt = 0;
   int               errors   = 0;
   int               checks   = 0;

   function automatic logic gray_check_on();
`ifdef GRAY_CHECK_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference model: sync is raw delayed SYNC edges; a bit flips once the last
   // STABLE synchronised samples all disagree with the clean level.
   initial forever begin
      logic [WIDTH-1:0] flips;
      logic             all_diff;
      @(posedge clk_i);
      edge_cnt++;
      if (rst_i) begin
         m_clean = '0;
         m_err   = 1'b0;
         m_line  = {};
         repeat (SYNC) m_line.push_back('0);
         m_hist  = {};
         m_hist.push_back('0);
      end else begin
         flips = '0;
         for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i][b] == m_clean[b]) all_diff = 1'b0;
            flips[b] = (m_hist.size() == STABLE) && all_diff;
         end
         if (flips != '0) begin
            m_clean = m_clean ^ flips;
            if (gray_check_on() && ($countones(flips) > 1)) m_err = 1'b1;
            exp_q.push_back('{m_clean, m_err, edge_cnt});
         end
         m_line.push_back(gray_raw_i);
         void'(m_line.pop_front());
         m_hist.push_back(m_line[0]);
         if (m_hist.size() > STABLE) void'(m_hist.pop_front());
      end
   end

   // Monitor: level checks every cycle, pulse checks against the scoreboard queue.
   initial forever begin
      exp_t e;
      @(negedge clk_i);
      chk("clean_level", 32'(gray_clean_o), 32'(m_clean));
      chk("err_level", 32'(gray_err_o), 32'(m_err));
      if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
         e = exp_q.pop_front();
         chk("change_pulse", 32'(change_o), 32'd1);
         chk("clean_at_pulse", 32'(gray_clean_o), 32'(e.clean));
         chk("err_at_pulse", 32'(gray_err_o), 32'(e.err));
      end else begin
         chk("no_change", 32'(change_o), 32'd0);
      end
   end

   task automatic drive(input logic r, input logic [WIDTH-1:0] v, input int n);
      rst_i      = r;
      gray_raw_i = v;
      repeat (n) @(negedge clk_i);
   endtask

   initial begin
      // Reset with all ones, then release: update after 10 edges.
      drive(1'b1, 4'b1111, 3);
      drive(1'b0, 4'b1111, 15);
      // Short glitch on bit0 is rejected.
      drive(1'b1, 4'b0000, 2);
      drive(1'b0, 4'b0000, 12);
      drive(1'b0, 4'b0001, 5);
      drive(1'b0, 4'b0000, 15);
      // Bounce train on bit2 then steady high.
      drive(1'b0, 4'b0100, 1);
      drive(1'b0, 4'b0000, 1);
      drive(1'b0, 4'b0100, 2);
      drive(1'b0, 4'b0000, 1);
      drive(1'b0, 4'b0100, 20);
      // Two-bit step at once, error held until reset.
      drive(1'b1, 4'b0000, 2);
      drive(1'b0, 4'b0000, 12);
      drive(1'b0, 4'b0011, 30);
      drive(1'b1, 4'b0000, 2);
      drive(1'b0, 4'b0000, 12);
      // Legal Gray steps 20 cycles apart.
      drive(1'b0, 4'b0001, 20);
      drive(1'b0, 4'b0011, 20);
      // Reset mid-count on bit0 falling, then count restarts.
      drive(1'b0, 4'b0010, 8);
      drive(1'b1, 4'b0010, 2);
      drive(1'b0, 4'b0010, 15);
      // Randomised bouncing switches with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         logic [WIDTH-1:0] v;
         v = gray_raw_i;
         if ($urandom_range(0, 15) == 0) v[$urandom_range(0, WIDTH-1)] = ~v[$urandom_range(0, WIDTH-1)];
         if ($urandom_range(0, 199) == 0) v = WIDTH'($urandom);
         drive(($urandom_range(0, 599) == 0), v, 1);
      end
      drive(1'b0, gray_raw_i, 20);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
